// File: rtl/cellram_responder.sv
// CellularRAM (PSRAM) pin-level responder.
// Emulates the async SRAM-style protocol: address latch on adv_n, fixed read
// latency with wait, byte-lane writes and BCR/RCR access through cre.
// Data lives in an internal single-port synchronous-read array; the tristate
// dq pin is split into dq_i / dq_o / dq_oe and the IOBUF lives above.
module cellram_responder #(
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned READ_LAT = 4,
    parameter logic [15:0] BCR_RST  = 16'h9D1F,
    parameter logic [15:0] RCR_RST  = 16'h0010
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        adv_n,
    input  logic        cre,
    input  logic        ce_n,
    input  logic        oe_n,
    input  logic        we_n,
    input  logic        lb_n,
    input  logic        ub_n,
    input  logic [22:0] addr,
    input  logic [15:0] dq_i,
    output logic [15:0] dq_o,
    output logic        dq_oe,
    output logic        o_wait,
    output logic [15:0] bcr,
    output logic [15:0] rcr
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_LAT  = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR      = 3'd3,
        ST_CFG_WR  = 3'd4
    } state_t;

    localparam int unsigned DEPTH    = 32'd1 << ADDR_W;
    localparam logic [3:0]  LAT_INIT = 4'(READ_LAT - 32'd1);

    // Config register read mux: addr[19:18] selects BCR (10) or RCR (00).
    function automatic logic [15:0] cfg_read(input logic [1:0]  sel,
                                             input logic [15:0] b,
                                             input logic [15:0] r);
        case (sel)
            2'b10:   return b;
            2'b00:   return r;
            default: return 16'h0000;
        endcase
    endfunction

    logic [15:0]       mem_q [DEPTH];
    logic [15:0]       rd_q;
    state_t            state_q;
    logic [22:0]       addr_q;
    logic              cre_q;
    logic [3:0]        cnt_q;
    logic [15:0]       dq_q;
    logic              oe_q;
    logic              wait_q;
    logic [15:0]       wdata_q;
    logic              lb_q;
    logic              ub_q;
    logic [15:0]       bcr_q;
    logic [15:0]       rcr_q;

    logic              latch_s;
    logic              in_wr_s;
    logic              commit_s;
    logic              mem_we_s;
    logic [ADDR_W-1:0] rd_idx_s;
    logic [ADDR_W-1:0] wr_idx_s;

    // Decode of latch / commit conditions and array addresses.
    always_comb begin
        latch_s  = ~ce_n & ~adv_n;
        in_wr_s  = (state_q == ST_WR) || (state_q == ST_CFG_WR);
        commit_s = in_wr_s & (we_n | ce_n);
        mem_we_s = commit_s & (state_q == ST_WR) & (~lb_q | ~ub_q);
        wr_idx_s = addr_q[ADDR_W-1:0];
        // Use the incoming address on a latching edge so a 1-cycle latency
        // still sees data for the freshly latched location.
        if (latch_s) begin
            rd_idx_s = addr[ADDR_W-1:0];
        end else begin
            rd_idx_s = addr_q[ADDR_W-1:0];
        end
    end

    // Single-port array: a write commit takes the port, otherwise a read is
    // issued every cycle so the word is ready one clk before the counter ends.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            if (!lb_q) mem_q[wr_idx_s][7:0]  <= wdata_q[7:0];
            if (!ub_q) mem_q[wr_idx_s][15:8] <= wdata_q[15:8];
        end else begin
            rd_q <= mem_q[rd_idx_s];
        end
    end

    // Protocol FSM with address latch, write holding register and config regs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            addr_q  <= 23'd0;
            cre_q   <= 1'b0;
            cnt_q   <= 4'd0;
            dq_q    <= 16'h0000;
            oe_q    <= 1'b0;
            wait_q  <= 1'b0;
            wdata_q <= 16'h0000;
            lb_q    <= 1'b1;
            ub_q    <= 1'b1;
            bcr_q   <= BCR_RST;
            rcr_q   <= RCR_RST;
        end else begin
            if (latch_s) begin
                addr_q <= addr;
                cre_q  <= cre;
            end
            // Holding register tracks the last cycle with we_n asserted.
            if (!ce_n && !we_n) begin
                wdata_q <= dq_i;
                lb_q    <= lb_n;
                ub_q    <= ub_n;
            end
            if (commit_s && (state_q == ST_CFG_WR)) begin
                case (addr_q[19:18])
                    2'b10:   bcr_q <= addr_q[15:0];
                    2'b00:   rcr_q <= addr_q[15:0];
                    default: ;
                endcase
            end
            case (state_q)
                ST_IDLE, ST_RD_DATA: begin
                    if (ce_n) begin
                        state_q <= ST_IDLE;
                        wait_q  <= 1'b0;
                        oe_q    <= 1'b0;
                    end else if (!we_n) begin
                        state_q <= cre ? ST_CFG_WR : ST_WR;
                        wait_q  <= 1'b0;
                        oe_q    <= 1'b0;
                    end else if (!adv_n) begin
                        state_q <= ST_RD_LAT;
                        cnt_q   <= LAT_INIT;
                        wait_q  <= 1'b1;
                        oe_q    <= 1'b0;
                    end
                end
                ST_RD_LAT: begin
                    if (ce_n) begin
                        state_q <= ST_IDLE;
                        wait_q  <= 1'b0;
                        oe_q    <= 1'b0;
                    end else if (latch_s && (addr != addr_q)) begin
                        cnt_q  <= LAT_INIT;
                        wait_q <= 1'b1;
                    end else if (cnt_q == 4'd0) begin
                        dq_q    <= cre_q ? cfg_read(addr_q[19:18], bcr_q, rcr_q) : rd_q;
                        state_q <= ST_RD_DATA;
                        wait_q  <= 1'b0;
                        oe_q    <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_WR, ST_CFG_WR: begin
                    wait_q <= 1'b0;
                    oe_q   <= 1'b0;
                    if (ce_n) begin
                        state_q <= ST_IDLE;
                    end else if (we_n) begin
                        if (!adv_n) begin
                            state_q <= ST_RD_LAT;
                            cnt_q   <= LAT_INIT;
                            wait_q  <= 1'b1;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    wait_q  <= 1'b0;
                    oe_q    <= 1'b0;
                end
            endcase
        end
    end

    // Chip-enable and output-enable gating is combinational so the pins
    // release immediately when the controller deselects.
    assign dq_o   = dq_q;
    assign dq_oe  = oe_q & ~ce_n & ~oe_n & we_n;
    assign o_wait = wait_q & ~ce_n;
    assign bcr    = bcr_q;
    assign rcr    = rcr_q;

endmodule

// File: tb/tb_cellram_responder.sv
// Directed bench for cellram_responder with a read-data scoreboard.
module tb_cellram_responder;

    localparam int          LAT  = 4;
    localparam logic [15:0] BRST = 16'h9D1F;
    localparam logic [15:0] RRST = 16'h0010;

    logic        clk;
    logic        reset_n;
    logic        adv_n, cre, ce_n, oe_n, we_n, lb_n, ub_n;
    logic [22:0] addr;
    logic [15:0] dq_i;
    logic [15:0] dq_o;
    logic        dq_oe;
    logic        o_wait;
    logic [15:0] bcr;
    logic [15:0] rcr;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] sb_q[$];
    logic [15:0] mdl [1024];
    logic [15:0] m_bcr;
    logic [15:0] m_rcr;

    cellram_responder #(
        .ADDR_W(10), .READ_LAT(LAT), .BCR_RST(BRST), .RCR_RST(RRST)
    ) dut (
        .clk(clk), .reset_n(reset_n), .adv_n(adv_n), .cre(cre), .ce_n(ce_n),
        .oe_n(oe_n), .we_n(we_n), .lb_n(lb_n), .ub_n(ub_n), .addr(addr),
        .dq_i(dq_i), .dq_o(dq_o), .dq_oe(dq_oe), .o_wait(o_wait),
        .bcr(bcr), .rcr(rcr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        ce_n = 1'b1; adv_n = 1'b1; we_n = 1'b1; oe_n = 1'b1;
        cre = 1'b0; lb_n = 1'b1; ub_n = 1'b1;
    endtask

    task automatic do_write(input logic [22:0] a, input logic [15:0] d,
                            input logic lb, input logic ub, input logic oe);
        ce_n = 1'b0; adv_n = 1'b0; we_n = 1'b0; oe_n = oe; cre = 1'b0;
        addr = a; dq_i = d; lb_n = lb; ub_n = ub;
        step();
        check("wr_wait", {31'd0, o_wait}, 32'd0);
        check("wr_dq_oe", {31'd0, dq_oe}, 32'd0);
        adv_n = 1'b1; we_n = 1'b1; oe_n = 1'b1; dq_i = 16'hDEAD;
        step();
        idle_bus();
        step();
        if (!lb) mdl[a[9:0]][7:0]  = d[7:0];
        if (!ub) mdl[a[9:0]][15:8] = d[15:8];
    endtask

    task automatic do_cfg_write(input logic [22:0] a);
        ce_n = 1'b0; adv_n = 1'b0; we_n = 1'b0; oe_n = 1'b1; cre = 1'b1;
        addr = a; dq_i = 16'hFFFF; lb_n = 1'b0; ub_n = 1'b0;
        step();
        adv_n = 1'b1; we_n = 1'b1;
        step();
        idle_bus();
        step();
        if (a[19:18] == 2'b10) m_bcr = a[15:0];
        if (a[19:18] == 2'b00) m_rcr = a[15:0];
        check("cfg_bcr", {16'd0, bcr}, {16'd0, m_bcr});
        check("cfg_rcr", {16'd0, rcr}, {16'd0, m_rcr});
    endtask

    // Waits (bounded) for o_wait to drop, then checks latency and data.
    task automatic wait_and_check(input string tag, input logic poke_we);
        int n;
        logic [15:0] expv;
        n = 0;
        while (o_wait === 1'b1 && n < 20) begin
            n++;
            step();
        end
        check({tag, "_lat"}, n, LAT);
        check({tag, "_dq_oe"}, {31'd0, dq_oe}, 32'd1);
        if (sb_q.size() > 0) begin
            expv = sb_q.pop_front();
            check({tag, "_data"}, {16'd0, dq_o}, {16'd0, expv});
        end else begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end
        if (poke_we) begin
            lb_n = 1'b1; ub_n = 1'b1; we_n = 1'b0;
            #1;
            check({tag, "_we_blocks_oe"}, {31'd0, dq_oe}, 32'd0);
            step();
            we_n = 1'b1;
            step();
        end
        idle_bus();
        step();
        check({tag, "_oe_off"}, {31'd0, dq_oe}, 32'd0);
    endtask

    task automatic do_read(input string tag, input logic [22:0] a, input logic cfg,
                           input logic [15:0] expv, input logic poke_we);
        ce_n = 1'b0; adv_n = 1'b0; we_n = 1'b1; oe_n = 1'b0; cre = cfg; addr = a;
        sb_q.push_back(expv);
        step();
        adv_n = 1'b1;
        wait_and_check(tag, poke_we);
    endtask

    initial begin
        reset_n = 1'b1;
        idle_bus();
        addr = 23'd0; dq_i = 16'h0000;
        m_bcr = BRST; m_rcr = RRST;
        #1 reset_n = 1'b0;
        #1;
        check("rst_dq_o", {16'd0, dq_o}, 32'd0);
        check("rst_dq_oe", {31'd0, dq_oe}, 32'd0);
        check("rst_wait", {31'd0, o_wait}, 32'd0);
        check("rst_bcr", {16'd0, bcr}, {16'd0, BRST});
        check("rst_rcr", {16'd0, rcr}, {16'd0, RRST});
        step();
        step();
        reset_n = 1'b1;
        step();

        // Word write then read.
        do_write(23'd5, 16'h1234, 1'b0, 1'b0, 1'b1);
        do_read("word", 23'd5, 1'b0, mdl[5], 1'b0);

        // Byte lanes: only the low byte is replaced.
        do_write(23'd7, 16'hAAAA, 1'b0, 1'b0, 1'b1);
        do_write(23'd7, 16'h5555, 1'b0, 1'b1, 1'b1);
        do_read("lane_lo", 23'd7, 1'b0, 16'hAA55, 1'b0);
        do_write(23'd8, 16'h0F0F, 1'b0, 1'b0, 1'b1);
        do_write(23'd8, 16'hC3C3, 1'b1, 1'b0, 1'b1);
        do_read("lane_hi", 23'd8, 1'b0, 16'hC30F, 1'b0);

        // Aliasing above the implemented depth.
        do_write(23'h7FFC03, 16'hBEEF, 1'b0, 1'b0, 1'b1);
        do_read("alias", 23'd3, 1'b0, 16'hBEEF, 1'b0);

        // Configuration registers.
        do_cfg_write(23'h08_1234);
        do_read("cfg_rd_bcr", 23'h08_1234, 1'b1, 16'h1234, 1'b0);
        do_cfg_write(23'h00_0055);
        do_cfg_write(23'h04_7777);
        do_read("cfg_rd_rcr", 23'h00_0000, 1'b1, 16'h0055, 1'b0);
        do_read("cfg_rd_other", 23'h0C_0000, 1'b1, 16'h0000, 1'b0);

        // Page restart: re-latch a different address mid-latency.
        do_write(23'd1, 16'h1111, 1'b0, 1'b0, 1'b1);
        do_write(23'd2, 16'h2222, 1'b0, 1'b0, 1'b1);
        ce_n = 1'b0; adv_n = 1'b0; we_n = 1'b1; oe_n = 1'b0; addr = 23'd1;
        step();
        adv_n = 1'b1;
        step();
        check("page_wait_mid", {31'd0, o_wait}, 32'd1);
        adv_n = 1'b0; addr = 23'd2;
        sb_q.push_back(16'h2222);
        step();
        adv_n = 1'b1;
        wait_and_check("page", 1'b0);

        // Write/read conflict: write wins, no drive.
        do_write(23'd9, 16'h9999, 1'b0, 1'b0, 1'b0);
        do_read("conflict", 23'd9, 1'b0, 16'h9999, 1'b1);
        do_read("no_lane_wr", 23'd9, 1'b0, 16'h9999, 1'b0);

        // Abort a read with ce_n.
        ce_n = 1'b0; adv_n = 1'b0; we_n = 1'b1; oe_n = 1'b0; addr = 23'd5;
        step();
        adv_n = 1'b1;
        step();
        check("abort_wait_pre", {31'd0, o_wait}, 32'd1);
        ce_n = 1'b1;
        #1;
        check("abort_wait_now", {31'd0, o_wait}, 32'd0);
        step();
        ce_n = 1'b0;
        #1;
        check("abort_wait_idle", {31'd0, o_wait}, 32'd0);
        step();
        step();
        check("abort_no_oe", {31'd0, dq_oe}, 32'd0);
        check("abort_wait_late", {31'd0, o_wait}, 32'd0);
        idle_bus();
        step();

        // Reset in the middle of a read latency.
        ce_n = 1'b0; adv_n = 1'b0; we_n = 1'b1; oe_n = 1'b0; addr = 23'd5;
        step();
        adv_n = 1'b1;
        step();
        check("rstmid_wait_pre", {31'd0, o_wait}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("rstmid_wait", {31'd0, o_wait}, 32'd0);
        check("rstmid_dq_oe", {31'd0, dq_oe}, 32'd0);
        m_bcr = BRST; m_rcr = RRST;
        check("rstmid_bcr", {16'd0, bcr}, {16'd0, m_bcr});
        check("rstmid_rcr", {16'd0, rcr}, {16'd0, m_rcr});
        idle_bus();
        step();
        reset_n = 1'b1;
        step();
        do_read("after_rst", 23'd5, 1'b0, 16'h1234, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cellram_responder.md
Name: cellram_responder

Overview:
- Synthesizable responder for the Micron CellularRAM (PSRAM) pin interface driven by the system's memory controller.
- Emulates the async-mode SRAM-style protocol: address latch on adv_n, read latency with wait, byte-lane writes, and BCR/RCR configuration access via cre.
- Backed by an internal block-RAM array, so controller changes can be exercised on-FPGA and in fast simulation without the vendor model.
- Tristate dq is split into dq_i, dq_o and dq_oe. The top level owns the IOBUF.

Parameters:
- ADDR_W, 10: word-address bits implemented; array depth is 2^ADDR_W x 16. Upper addr bits are ignored (aliasing).
- READ_LAT, 4: clk cycles from read-address latch to valid dq. Legal range is 1..15.
- BCR_RST, 16'h9D1F: bus configuration register reset value.
- RCR_RST, 16'h0010: refresh configuration register reset value.

Ports:
- clk, in, 1: responder clock. All memory-side inputs are synchronous to clk.
- reset_n, in, 1: asynchronous, active-low reset.
- adv_n, in, 1: address valid, active low.
- cre, in, 1: configuration register enable.
- ce_n, in, 1: chip enable, active low.
- oe_n, in, 1: output enable, active low.
- we_n, in, 1: write enable, active low.
- lb_n, in, 1: lower byte enable (dq[7:0]), active low.
- ub_n, in, 1: upper byte enable (dq[15:8]), active low.
- addr, in, 23: word address; carries config data when cre=1.
- dq_i, in, 16: data from pins.
- dq_o, out, 16: data to pins.
- dq_oe, out, 1: drive enable for dq.
- o_wait, out, 1: active-high wait; 1 = data not yet valid.
- bcr, out, 16: current BCR, for debug.
- rcr, out, 16: current RCR, for debug.

Behaviour:
- Reset (async, reset_n=0):
  - State=IDLE.
  - dq_o=0, dq_oe=0, o_wait=0, latency counter=0.
  - bcr=BCR_RST, rcr=RCR_RST.
  - Array contents are preserved.
- Address latch: on every clk with ce_n=0 and adv_n=0, the internal address register loads addr. With adv_n=1 it holds.
- States: IDLE, RD_LAT, RD_DATA, WR, CFG_WR.
- IDLE:
  - ce_n=0, adv_n=0, we_n=1 → RD_LAT, counter=READ_LAT-1, o_wait=1.
  - ce_n=0, we_n=0, cre=0 → WR.
  - ce_n=0, we_n=0, cre=1 → CFG_WR.
- RD_LAT:
  - Counter decrements each clk; o_wait=1.
  - At counter=0, the array (cre=0) or register (cre=1) is read into dq_o → RD_DATA, o_wait=0.
  - Data is valid exactly READ_LAT clks after the latching edge.
  - A new adv_n=0 with a different addr restarts RD_LAT.
- RD_DATA:
  - dq_oe = (ce_n==0 && oe_n==0 && we_n==1), combinationally gated.
  - A new adv_n=0 (page access) → RD_LAT.
- Config read (cre=1 at latch):
  - addr[19:18]=2'b10 returns BCR.
  - addr[19:18]=2'b00 returns RCR.
  - Any other value returns 16'h0000.
- WR:
  - Every clk with we_n=0: a data/byte-enable holding register samples dq_i, lb_n, ub_n.
  - Commit on the first clk where we_n=1 or ce_n=1, using the last sampled values; then → IDLE (ce_n=1) or RD_LAT rules.
  - Only enabled bytes are written. lb_n=ub_n=1 writes nothing.
  - o_wait=0, dq_oe=0 throughout.
- CFG_WR:
  - On commit, as in WR: addr[19:18]=2'b10 → bcr=addr[15:0]; 2'b00 → rcr=addr[15:0]; other values are ignored.
  - dq and byte enables are ignored.
- ce_n=1 in any state:
  - → IDLE next clk; o_wait=0, dq_oe=0 immediately (combinational).
  - A pending write is committed first.
- Simultaneous we_n=0 and oe_n=0: write wins and dq_oe=0.
- Address beyond 2^ADDR_W aliases modulo depth.
- Array is single-port with synchronous read; its read is issued one clk before the counter reaches 0, to meet the latency.

Test Plan:
- Word write then read: write 16'h1234 to addr 5 (lb_n=ub_n=0), then read addr 5 → o_wait=1 for 4 clks, then dq_o=16'h1234 with dq_oe=1 while oe_n=0.
- Byte lanes: preload addr 7=16'hAAAA, write 16'h5555 with lb_n=0, ub_n=1 → read returns 16'hAA55.
- Config: cre=1 write with addr=23'h08_1234 (addr[19:18]=2'b10) → bcr=16'h1234, rcr unchanged at 16'h0010; cre=1 read of the same addr → dq_o=16'h1234.
- Page restart: latch addr 1, then re-latch addr 2 at latency cycle 2 → o_wait stays 1 for 4 clks after the second latch, then data of addr 2.
- Reset mid-read: reset_n=0 during RD_LAT → dq_oe=0 and o_wait=0 asynchronously; after release, addr 5 still reads 16'h1234.
- Abort and conflict: ce_n=1 during RD_LAT → o_wait=0 next edge and no dq_oe; we_n=0 with oe_n=0 → dq_oe stays 0 and the write commits.
